// File: rtl/mdu_unit_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package mdu_unit_pkg;

    localparam int unsigned MDU_WIDTH      = 64;
    localparam int unsigned MDU_DIV_ITERS  = 64;
    localparam int unsigned MDU_DIVW_ITERS = 32;

    typedef logic [MDU_WIDTH-1:0] word_t;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MUL   = 4'd1,
        MDU_MULW  = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_REM   = 4'd5,
        MDU_REMU  = 4'd6,
        MDU_DIVW  = 4'd7,
        MDU_DIVUW = 4'd8,
        MDU_REMW  = 4'd9,
        MDU_REMUW = 4'd10
    } mdu_op_t;

    typedef enum logic [2:0] {
        MDU_S_IDLE,
        MDU_S_MULT,
        MDU_S_DIVI,
        MDU_S_SIGN,
        MDU_S_DONE
    } mdu_state_t;

    function automatic logic is_mul(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULW);
    endfunction

    function automatic logic is_word(input mdu_op_t op);
        return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    endfunction

    function automatic logic is_signed_div(input mdu_op_t op);
        return op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    endfunction

    function automatic logic is_rem(input mdu_op_t op);
        return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Request/response bundle between execute (master) and the MDU (slave).
interface mdu_unit_if
    import mdu_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
);
    logic             valid;
    mdu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output valid, op, a, b, flush, input ready, done, result);
    modport slave  (input valid, op, a, b, flush, output ready, done, result);
endinterface

// File: rtl/mdu_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
module mdu_unit_div_core
    import mdu_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             word,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done_c,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Trial subtract needs one extra bit: shifted remainder may reach 2*divisor-1.
    always_comb begin
        trial = {remainder, quotient[WIDTH-1]};
        diff  = trial - {1'b0, dsr};
    end

    assign done_c = busy && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= word ? CNT_W'(MDU_DIVW_ITERS - 1) : CNT_W'(MDU_DIV_ITERS - 1);
            quotient  <= word ? {dividend[HALF-1:0], {HALF{1'b0}}} : dividend;
            remainder <= '0;
            dsr       <= divisor;
        end else if (busy) begin
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle RV64M multiply/divide responder sitting beside the ALU in execute.
// Owns control FSM, operand prep, special cases, sign fixup and the multiplier.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    mdu_unit_if.slave bus
);
    localparam int unsigned HALF = WIDTH / 2;

    mdu_state_t       state, state_n;
    mdu_op_t          op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             neg_q, neg_r;

    logic             accept_c, special_c, w_op_c, s_op_c;
    logic             sgn_a_c, sgn_b_c, div_zero_c, div_ovf_c;
    logic [WIDTH-1:0] a_sx_c, b_sx_c, ext_a_c, ext_b_c, mag_a_c, mag_b_c, special_res_c;

    logic             div_start_c, div_busy, div_done_c;
    logic [WIDTH-1:0] quo, rem;

    logic [WIDTH-1:0] prod_c, q_fix_c, r_fix_c, pick_c, result_n;
    logic             result_en;

    // Operand prep and special-case detection on the live request.
    always_comb begin
        w_op_c  = is_word(bus.op);
        s_op_c  = is_signed_div(bus.op);
        a_sx_c  = {{HALF{bus.a[HALF-1]}}, bus.a[HALF-1:0]};
        b_sx_c  = {{HALF{bus.b[HALF-1]}}, bus.b[HALF-1:0]};
        ext_a_c = bus.a;
        ext_b_c = bus.b;
        if (w_op_c) begin
            ext_a_c = s_op_c ? a_sx_c : {{HALF{1'b0}}, bus.a[HALF-1:0]};
            ext_b_c = s_op_c ? b_sx_c : {{HALF{1'b0}}, bus.b[HALF-1:0]};
        end
        sgn_a_c    = s_op_c & ext_a_c[WIDTH-1];
        sgn_b_c    = s_op_c & ext_b_c[WIDTH-1];
        mag_a_c    = sgn_a_c ? -ext_a_c : ext_a_c;
        mag_b_c    = sgn_b_c ? -ext_b_c : ext_b_c;
        div_zero_c = (ext_b_c == '0);
        div_ovf_c  = s_op_c && (ext_b_c == '1) &&
                     (ext_a_c == (w_op_c ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}}));
        special_c  = !is_mul(bus.op) && (div_zero_c || div_ovf_c);
        if (div_zero_c)
            special_res_c = is_rem(bus.op) ? (w_op_c ? a_sx_c : bus.a) : '1;
        else
            special_res_c = is_rem(bus.op) ? '0 : (w_op_c ? a_sx_c : bus.a);
        accept_c = bus.valid && (state == MDU_S_IDLE) && !bus.flush && (bus.op != MDU_NOP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MDU_S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            MDU_S_IDLE: if (accept_c)
                            state_n = is_mul(bus.op) ? MDU_S_MULT :
                                      special_c      ? MDU_S_DONE : MDU_S_DIVI;
            MDU_S_MULT: state_n = MDU_S_DONE;
            MDU_S_DIVI: if (div_done_c || !div_busy) state_n = MDU_S_SIGN;
            MDU_S_SIGN: state_n = MDU_S_DONE;
            MDU_S_DONE: state_n = MDU_S_IDLE;
            default:    state_n = MDU_S_IDLE;
        endcase
        if (bus.flush) state_n = MDU_S_IDLE;
    end

    // Result selection; a flush suppresses any load so the old result survives.
    always_comb begin
        div_start_c = 1'b0;
        result_en   = 1'b0;
        result_n    = '0;
        prod_c      = a_q * b_q;
        q_fix_c     = neg_q ? -quo : quo;
        r_fix_c     = neg_r ? -rem : rem;
        pick_c      = is_rem(op_q) ? r_fix_c : q_fix_c;
        unique case (state)
            MDU_S_IDLE: if (accept_c) begin
                div_start_c = !is_mul(bus.op) && !special_c;
                result_en   = special_c;
                result_n    = special_res_c;
            end
            MDU_S_MULT: begin
                result_en = !bus.flush;
                result_n  = (op_q == MDU_MULW) ? {{HALF{prod_c[HALF-1]}}, prod_c[HALF-1:0]} : prod_c;
            end
            MDU_S_SIGN: begin
                result_en = !bus.flush;
                result_n  = is_word(op_q) ? {{HALF{pick_c[HALF-1]}}, pick_c[HALF-1:0]} : pick_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= MDU_NOP;
            a_q        <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            bus.ready  <= 1'b1;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.ready <= (state_n == MDU_S_IDLE);
            bus.done  <= (state_n == MDU_S_DONE);
            if (accept_c) begin
                op_q  <= bus.op;
                a_q   <= bus.a;
                b_q   <= bus.b;
                neg_q <= sgn_a_c ^ sgn_b_c;
                neg_r <= sgn_a_c;
            end
            if (result_en) bus.result <= result_n;
        end
    end

    mdu_unit_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_c),
        .abort     (bus.flush),
        .word      (w_op_c),
        .dividend  (mag_a_c),
        .divisor   (mag_b_c),
        .busy      (div_busy),
        .done_c    (div_done_c),
        .quotient  (quo),
        .remainder (rem)
    );

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vectors plus random ops against an arithmetic model.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] last_res;

    mdu_unit_if #(.WIDTH(64)) bus();
    mdu_unit #(.WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    localparam int NV = 14;
    mdu_op_t v_op [NV] = '{MDU_MUL, MDU_MULW, MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU, MDU_DIVW,
                           MDU_DIVUW, MDU_DIVW, MDU_REMW, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMUW};
    logic [63:0] v_a [NV] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9,
                              64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100, 64'h1234_5678_FFFF_FFF9,
                              64'hFFFF_FFFE, 64'h8000_0000, 64'h8000_0000, 64'h8000_0000_0000_0000,
                              64'd5, 64'd5, 64'h1_8000_0000};
    logic [63:0] v_b [NV] = '{64'd3, 64'd2, 64'd2, 64'd2, 64'd7, 64'd7, 64'd2, 64'd1,
                              64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0};
    logic [63:0] v_e [NV] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_8000_0000, 64'd0,
                              64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
                              64'hFFFF_FFFF_8000_0000};
    int v_lat [NV] = '{2, 2, 66, 66, 66, 66, 34, 34, 1, 1, 1, 1, 1, 1};

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural result of an RV64M op, straight from the ISA rules.
    function automatic logic [63:0] model(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [31:0] aw, bw, tw;
        logic signed [63:0] sa, sb;
        logic signed [31:0] saw, sbw;
        aw = a[31:0]; bw = b[31:0]; sa = a; sb = b; saw = aw; sbw = bw;
        r = '0;
        case (op)
            MDU_MUL:   r = a * b;
            MDU_MULW:  begin tw = aw * bw; r = sx32(tw); end
            MDU_DIV:   if (b == 0) r = '1;
                       else if (sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1) r = a;
                       else r = 64'(sa / sb);
            MDU_REM:   if (b == 0) r = a;
                       else if (sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1) r = '0;
                       else r = 64'(sa % sb);
            MDU_DIVU:  r = (b == 0) ? '1 : a / b;
            MDU_REMU:  r = (b == 0) ? a : a % b;
            MDU_DIVW:  if (bw == 0) r = '1;
                       else if (saw == 32'sh8000_0000 && sbw == -32'sd1) r = sx32(aw);
                       else r = sx32(32'(saw / sbw));
            MDU_REMW:  if (bw == 0) r = sx32(aw);
                       else if (saw == 32'sh8000_0000 && sbw == -32'sd1) r = '0;
                       else r = sx32(32'(saw % sbw));
            MDU_DIVUW: r = (bw == 0) ? '1 : sx32(aw / bw);
            MDU_REMUW: r = (bw == 0) ? sx32(aw) : sx32(aw % bw);
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b);
        bit w;
        w = op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
        if (op == MDU_MUL || op == MDU_MULW) return 2;
        if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
        if (op inside {MDU_DIV, MDU_REM} && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        if (op inside {MDU_DIVW, MDU_REMW} && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] r;
        case ($urandom_range(0, 6))
            0:       r = 64'd0;
            1:       r = '1;
            2:       r = 64'h8000_0000_0000_0000;
            3:       r = {$urandom, 32'h8000_0000};
            4:       r = 64'($urandom_range(0, 20));
            5:       r = {32'hFFFF_FFFF, $urandom};
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.ready && w < 200) begin @(negedge clk); w++; end
    endtask

    // Issue one request and count cycles from the accept edge to the done pulse.
    task automatic run_op(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int cyc);
        wait_ready();
        bus.valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
        cyc = 1;
        while (!bus.done && cyc < 200) begin @(posedge clk); #1; cyc++; end
        res = bus.result;
        bus.valid = 1'b0; bus.op = MDU_NOP;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.ready); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.result !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
        @(negedge clk); reset = 1'b0;
        last_res = '0;
    endtask

    task automatic test_mul();
        logic [63:0] res; int cyc;
        for (int i = 0; i < 2; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], res, cyc);
            n_checks++; if (res !== v_e[i]) begin n_fail++; $display("FAIL mul[%0d] result got %h want %h", i, res, v_e[i]); end
            n_checks++; if (cyc != v_lat[i]) begin n_fail++; $display("FAIL mul[%0d] latency got %0d want %0d", i, cyc, v_lat[i]); end
            last_res = v_e[i];
        end
    endtask

    task automatic test_div();
        logic [63:0] res; int cyc;
        for (int i = 2; i < 8; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], res, cyc);
            n_checks++; if (res !== v_e[i]) begin n_fail++; $display("FAIL div[%0d] result got %h want %h", i, res, v_e[i]); end
            n_checks++; if (cyc != v_lat[i]) begin n_fail++; $display("FAIL div[%0d] latency got %0d want %0d", i, cyc, v_lat[i]); end
            last_res = v_e[i];
        end
    endtask

    task automatic test_special();
        logic [63:0] res; int cyc;
        for (int i = 8; i < NV; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], res, cyc);
            n_checks++; if (res !== v_e[i]) begin n_fail++; $display("FAIL special[%0d] result got %h want %h", i, res, v_e[i]); end
            n_checks++; if (cyc != v_lat[i]) begin n_fail++; $display("FAIL special[%0d] latency got %0d want %0d", i, cyc, v_lat[i]); end
            last_res = v_e[i];
        end
    endtask

    task automatic test_flush();
        logic [63:0] prev, res; logic saw_done; int cyc;
        // Flush raised in the DONE cycle must not cancel that pulse.
        wait_ready();
        bus.valid = 1'b1; bus.op = MDU_DIVU; bus.a = 64'd5; bus.b = 64'd0;
        @(posedge clk); #1;
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL flush_done_cycle done got %b want 1", bus.done); end
        bus.flush = 1'b1; #2;
        n_checks++; if (bus.done !== 1'b1 || bus.result !== '1)
            begin n_fail++; $display("FAIL flush_done_hold done=%b result=%h want 1/ffffffffffffffff", bus.done, bus.result); end
        @(posedge clk); #1;
        n_checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0)
            begin n_fail++; $display("FAIL flush_after_done ready=%b done=%b want 1/0", bus.ready, bus.done); end
        bus.flush = 1'b0; bus.valid = 1'b0; bus.op = MDU_NOP;
        last_res = '1;

        prev = last_res; saw_done = 1'b0;
        wait_ready();
        bus.valid = 1'b1; bus.op = MDU_DIV; bus.a = 64'd1000; bus.b = 64'd3;
        @(posedge clk); #1; cyc = 1;
        if (bus.done) saw_done = 1'b1;
        while (cyc < 10) begin @(posedge clk); #1; cyc++; if (bus.done) saw_done = 1'b1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        if (bus.done) saw_done = 1'b1;
        n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", bus.ready); end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done got %b want 0", saw_done); end
        n_checks++; if (bus.result !== prev) begin n_fail++; $display("FAIL flush_result got %h want %h", bus.result, prev); end
        bus.flush = 1'b0; bus.valid = 1'b0; bus.op = MDU_NOP;
        repeat (3) begin @(posedge clk); #1; if (bus.done) saw_done = 1'b1; end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_late_done got %b want 0", saw_done); end
        run_op(MDU_DIVU, 64'd9, 64'd3, res, cyc);
        n_checks++; if (res !== 64'd3) begin n_fail++; $display("FAIL flush_next result got %h want 3", res); end
        n_checks++; if (cyc != 66) begin n_fail++; $display("FAIL flush_next latency got %0d want 66", cyc); end
        last_res = 64'd3;
    endtask

    task automatic test_nop();
        logic ok;
        wait_ready();
        ok = 1'b1;
        bus.valid = 1'b1; bus.op = MDU_NOP; bus.a = {$urandom, $urandom}; bus.b = 64'd0;
        repeat (10) begin @(posedge clk); #1; if (bus.ready !== 1'b1 || bus.done !== 1'b0) ok = 1'b0; end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL nop_ignored got %b want 1", ok); end
        ok = 1'b1;
        bus.op = MDU_MUL; bus.flush = 1'b1;
        repeat (5) begin @(posedge clk); #1; if (bus.ready !== 1'b1 || bus.done !== 1'b0) ok = 1'b0; end
        bus.flush = 1'b0; bus.valid = 1'b0; bus.op = MDU_NOP;
        repeat (3) begin @(posedge clk); #1; if (bus.done !== 1'b0) ok = 1'b0; end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL flush_valid_ignored got %b want 1", ok); end
        n_checks++; if (bus.result !== last_res) begin n_fail++; $display("FAIL nop_result got %h want %h", bus.result, last_res); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2; int cyc;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        wait_ready();
        bus.valid = 1'b1; bus.op = MDU_MUL; bus.a = a1; bus.b = b1;
        @(posedge clk); #1; cyc = 1;
        while (!bus.done && cyc < 10) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL b2b_first latency got %0d want 2", cyc); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ready got %b want 0", bus.ready); end
        n_checks++; if (bus.result !== 64'(a1 * b1)) begin n_fail++; $display("FAIL b2b_first result got %h want %h", bus.result, 64'(a1 * b1)); end
        bus.a = a2; bus.b = b2;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!bus.done && cyc < 10);
        n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL b2b_second gap got %0d want 3", cyc); end
        n_checks++; if (bus.result !== 64'(a2 * b2)) begin n_fail++; $display("FAIL b2b_second result got %h want %h", bus.result, 64'(a2 * b2)); end
        bus.valid = 1'b0; bus.op = MDU_NOP;
        last_res = 64'(a2 * b2);
    endtask

    task automatic test_reset_mid();
        logic ok;
        wait_ready();
        bus.valid = 1'b1; bus.op = MDU_DIV; bus.a = {$urandom, $urandom}; bus.b = 64'd7;
        repeat (20) @(posedge clk); #1;
        reset = 1'b1; #1;
        n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", bus.ready); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
        n_checks++; if (bus.result !== 64'd0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", bus.result); end
        bus.valid = 1'b0; bus.op = MDU_NOP;
        @(negedge clk); reset = 1'b0;
        ok = 1'b1;
        repeat (70) begin @(posedge clk); #1; if (bus.done !== 1'b0) ok = 1'b0; end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_mid_no_done got %b want 1", ok); end
        last_res = '0;
    endtask

    task automatic test_random();
        logic [63:0] a, b, res, exp; int cyc, lat; mdu_op_t op;
        for (int i = 0; i < 60; i++) begin
            op  = mdu_op_t'(4'($urandom_range(1, 10)));
            a   = pick();
            b   = pick();
            exp = model(op, a, b);
            lat = model_lat(op, a, b);
            run_op(op, a, b, res, cyc);
            n_checks++; if (res !== exp)
                begin n_fail++; $display("FAIL rand[%0d] %s a=%h b=%h result got %h want %h", i, op.name(), a, b, res, exp); end
            n_checks++; if (cyc != lat)
                begin n_fail++; $display("FAIL rand[%0d] %s latency got %0d want %0d", i, op.name(), cyc, lat); end
            last_res = exp;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0; bus.op = MDU_NOP; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
